// File: rtl/mem_responder_pkg.sv
// Shared memory-interface definitions: transfer size codes and responder FSM states.
package mem_responder_pkg;

  // Transfer size codes carried on the width bus
  typedef enum logic [1:0] {
    RAM_WIDTH8  = 2'd0,
    RAM_WIDTH16 = 2'd1,
    RAM_WIDTH32 = 2'd2,
    RAM_WIDTH64 = 2'd3
  } ram_width_t;

  // Responder transaction states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_lane_mux.sv
// Byte-lane steering: aligns the offset to the transfer size, builds the lane
// mask, merges write data into the old word and extracts right-justified read data.
module mem_lane_mux
  import mem_responder_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [2:0]  offset,
  input  logic [63:0] old_word,
  input  logic [63:0] wdata,
  output logic [63:0] mask,
  output logic [63:0] merged,
  output logic [63:0] rdata
);

  logic [2:0]  aligned;
  logic [5:0]  shift;
  logic [63:0] size_mask;

  // Natural alignment, lane mask, write merge and read extraction
  always_comb begin
    aligned   = offset;
    size_mask = '1;
    case (ram_width_t'(width))
      RAM_WIDTH8:  begin aligned = offset;                size_mask = 64'h0000_0000_0000_00FF; end
      RAM_WIDTH16: begin aligned = {offset[2:1], 1'b0};   size_mask = 64'h0000_0000_0000_FFFF; end
      RAM_WIDTH32: begin aligned = {offset[2], 2'b00};    size_mask = 64'h0000_0000_FFFF_FFFF; end
      RAM_WIDTH64: begin aligned = 3'b000;                size_mask = '1; end
      default:     begin aligned = 3'b000;                size_mask = '1; end
    endcase
    shift  = {aligned, 3'b000};
    mask   = size_mask << shift;
    merged = (old_word & ~mask) | ((wdata & size_mask) << shift);
    rdata  = (old_word >> shift) & size_mask;
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one read or write strobe while idle,
// waits LATENCY cycles, then performs the access and pulses transaction_complete.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic [27:0] addr,
  input  logic [1:0]  width,
  input  logic [63:0] data_in,
  input  logic        rstrobe,
  input  logic        wstrobe,
  output logic [63:0] data_out,
  output logic        transaction_complete,
  output logic        ready
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(LATENCY);

  mem_state_t        state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  word_lat;
  logic [2:0]        off_lat;
  logic [1:0]        width_lat;
  logic [63:0]       data_lat;
  logic              is_write;
  logic              accept;
  logic              finish;
  logic [63:0]       mem [DEPTH_WORDS];
  logic [63:0]       old_word;
  logic [63:0]       merged;
  logic [63:0]       rd_data;
  logic [63:0]       lane_mask_unused;
  logic              addr_hi_unused;

  // Address bits above the word index are deliberately ignored (wrap-around)
  assign addr_hi_unused = ^addr[27:3+IDX_W];

  assign accept   = (state == IDLE) && (rstrobe || wstrobe);
  // Last BUSY cycle: the array/data_out update happens on the DONE-entry edge
  assign finish   = (state == BUSY) && (cnt == CNT_W'(1));
  assign old_word = mem[word_lat];

  mem_lane_mux u_lane_mux (
    .width    (width_lat),
    .offset   (off_lat),
    .old_word (old_word),
    .wdata    (data_lat),
    .mask     (lane_mask_unused),
    .merged   (merged),
    .rdata    (rd_data)
  );

  // State register
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state           = state;
    ready                = 1'b0;
    transaction_complete = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (rstrobe || wstrobe) next_state = BUSY;
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) next_state = DONE;
      end
      DONE: begin
        transaction_complete = 1'b1;
        next_state           = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latches and latency counter
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      word_lat  <= '0;
      off_lat   <= '0;
      width_lat <= '0;
      data_lat  <= '0;
      is_write  <= 1'b0;
    end else if (accept) begin
      cnt       <= CNT_W'(LATENCY - 1);
      word_lat  <= addr[3 +: IDX_W];
      off_lat   <= addr[2:0];
      width_lat <= width;
      data_lat  <= data_in;
      is_write  <= wstrobe;
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Read data register, updated only by completing reads
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n)                   data_out <= '0;
    else if (finish && !is_write) data_out <= rd_data;
  end

  // Storage array, not reset; read-modify-write of the selected lanes
  always_ff @(posedge clk_cpu) begin
    if (finish && is_write) mem[word_lat] <= merged;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table of transactions with a data_out
// scoreboard, plus hand sequences for ignored strobes, simultaneous strobes and reset abort.
module tb_mem_responder;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 256;

  logic        clk_cpu = 1'b0;
  logic        rst_n;
  logic [27:0] addr;
  logic [1:0]  width;
  logic [63:0] data_in;
  logic        rstrobe;
  logic        wstrobe;
  logic [63:0] data_out;
  logic        transaction_complete;
  logic        ready;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];
  logic [63:0] exp_dout;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [27:0] addr;
    logic [1:0]  width;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [$];

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_cpu              (clk_cpu),
    .rst_n                (rst_n),
    .addr                 (addr),
    .width                (width),
    .data_in              (data_in),
    .rstrobe              (rstrobe),
    .wstrobe              (wstrobe),
    .data_out             (data_out),
    .transaction_complete (transaction_complete),
    .ready                (ready)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One transaction; optionally fires a stray rstrobe while the DUT is busy
  task automatic run_op(input string name, input logic wr, input logic rd,
                        input logic [27:0] a, input logic [1:0] w,
                        input logic [63:0] d, input logic [63:0] exp, input logic inject);
    int lat;
    logic [63:0] e;
    lat = 0;
    @(negedge clk_cpu);
    addr = a; width = w; data_in = d; wstrobe = wr; rstrobe = rd;
    if (wr) exp_q.push_back(exp_dout);
    else begin
      exp_q.push_back(exp);
      exp_dout = exp;
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_cpu); #1;
      if (i == 1) begin rstrobe = 1'b0; wstrobe = 1'b0; end
      if (transaction_complete) begin lat = i; break; end
      if (inject && i == 2) begin rstrobe = 1'b1; addr = 28'h10; width = 2'd3; end
      if (inject && i == 3) rstrobe = 1'b0;
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_complete required=complete", name);
      rstrobe = 1'b0;
    end else begin
      check({name, "_latency"}, 64'(lat), 64'(LAT));
      check({name, "_ready_done"}, 64'(ready), 64'd0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s_scoreboard actual=empty required=entry", name);
      end else begin
        e = exp_q.pop_front();
        check({name, "_data_out"}, data_out, e);
      end
      @(posedge clk_cpu); #1;
      check({name, "_ready_after"}, 64'(ready), 64'd1);
      check({name, "_complete_once"}, 64'(transaction_complete), 64'd0);
    end
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; addr = '0; width = '0; data_in = '0; rstrobe = 1'b0; wstrobe = 1'b0;
    exp_dout = '0;

    // Reset state
    repeat (2) @(posedge clk_cpu);
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_complete", 64'(transaction_complete), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    @(negedge clk_cpu) rst_n = 1'b1;

    //          wr    rd    addr        w     data                    expected read data
    vecs.push_back('{1'b1, 1'b0, 28'h10,     2'd3, 64'h0123_4567_89AB_CDEF, 64'h0});
    vecs.push_back('{1'b0, 1'b1, 28'h10,     2'd3, 64'h0,                   64'h0123_4567_89AB_CDEF});
    vecs.push_back('{1'b1, 1'b0, 28'h10,     2'd3, 64'h0,                   64'h0});
    vecs.push_back('{1'b1, 1'b0, 28'h13,     2'd0, 64'hFFFF_FFFF_FFFF_FFAA, 64'h0});
    vecs.push_back('{1'b0, 1'b1, 28'h10,     2'd3, 64'h0,                   64'h0000_0000_AA00_0000});
    vecs.push_back('{1'b0, 1'b1, 28'h13,     2'd0, 64'h0,                   64'h0000_0000_0000_00AA});
    vecs.push_back('{1'b1, 1'b0, 28'h10,     2'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'h0});
    vecs.push_back('{1'b0, 1'b1, 28'h16,     2'd2, 64'h0,                   64'h0000_0000_DEAD_BEEF});
    vecs.push_back('{1'b0, 1'b1, 28'h13,     2'd1, 64'h0,                   64'h0000_0000_0000_CAFE});
    vecs.push_back('{1'b0, 1'b1, 28'h15,     2'd0, 64'h0,                   64'h0000_0000_0000_00BE});
    vecs.push_back('{1'b1, 1'b0, 28'h11,     2'd1, 64'hFFFF_FFFF_FFFF_1234, 64'h0});
    vecs.push_back('{1'b0, 1'b1, 28'h10,     2'd3, 64'h0,                   64'hDEAD_BEEF_CAFE_1234});
    vecs.push_back('{1'b1, 1'b0, 28'h800,    2'd3, 64'h5555_AAAA_5555_AAAA, 64'h0});
    vecs.push_back('{1'b0, 1'b1, 28'h0,      2'd3, 64'h0,                   64'h5555_AAAA_5555_AAAA});
    vecs.push_back('{1'b0, 1'b1, 28'hFFFF807,2'd3, 64'h0,                   64'h5555_AAAA_5555_AAAA});
    vecs.push_back('{1'b0, 1'b1, 28'h804,    2'd2, 64'h0,                   64'h0000_0000_5555_AAAA});

    foreach (vecs[k])
      run_op($sformatf("vec%0d", k), vecs[k].wr, vecs[k].rd, vecs[k].addr,
             vecs[k].width, vecs[k].data, vecs[k].exp, 1'b0);

    // Stray rstrobe during BUSY of a write: ignored, data_out unchanged, no second pulse
    run_op("busy_strobe", 1'b1, 1'b0, 28'h20, 2'd3, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1'b1);
    pulses = 0;
    repeat (LAT + 4) begin @(posedge clk_cpu); #1; pulses += int'(transaction_complete); end
    check("busy_strobe_no_extra", 64'(pulses), 64'd0);
    run_op("busy_strobe_rd", 1'b0, 1'b1, 28'h20, 2'd3, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);

    // Both strobes together: write wins, data_out unchanged
    run_op("both_strobes", 1'b1, 1'b1, 28'h28, 2'd3, 64'h1357_9BDF_2468_ACE0, 64'h0, 1'b0);
    run_op("both_strobes_rd", 1'b0, 1'b1, 28'h28, 2'd3, 64'h0, 64'h1357_9BDF_2468_ACE0, 1'b0);

    // Reset during BUSY of a write aborts it
    run_op("old_wr", 1'b1, 1'b0, 28'h30, 2'd3, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 1'b0);
    @(negedge clk_cpu);
    addr = 28'h30; width = 2'd3; data_in = 64'h1111_2222_3333_4444; wstrobe = 1'b1;
    @(posedge clk_cpu); #1 wstrobe = 1'b0;
    @(posedge clk_cpu); #1;
    check("abort_busy_ready", 64'(ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_data_out", data_out, 64'd0);
    pulses = 0;
    repeat (3) begin @(posedge clk_cpu); #1; pulses += int'(transaction_complete); end
    @(negedge clk_cpu) rst_n = 1'b1;
    exp_dout = '0;
    repeat (LAT + 2) begin @(posedge clk_cpu); #1; pulses += int'(transaction_complete); end
    check("abort_no_complete", 64'(pulses), 64'd0);
    check("abort_ready_after", 64'(ready), 64'd1);
    run_op("abort_rd", 1'b0, 1'b1, 28'h30, 2'd3, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
